// File: rtl/alu_seq_pkg.sv
// Shared widths, opcodes and FSM encoding for the ALU command sequencer.
package alu_seq_pkg;

   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 2;
   localparam int OP_W     = 8;
   localparam int RF_DEPTH = 4;

   localparam logic [OP_W-1:0] OP_LOADI  = 8'h00;
   localparam logic [OP_W-1:0] OP_ADD    = 8'h01;
   localparam logic [OP_W-1:0] OP_SUB    = 8'h02;
   localparam logic [OP_W-1:0] OP_CPL    = 8'h0E;
   localparam logic [OP_W-1:0] OP_AND    = 8'h0F;
   localparam logic [OP_W-1:0] OP_OR     = 8'h10;
   localparam logic [OP_W-1:0] OP_XOR    = 8'h11;
   localparam logic [OP_W-1:0] OP_RSHIFT = 8'h13;
   localparam logic [OP_W-1:0] OP_LSHIFT = 8'h14;

   // The ALU treats 00 as "not an ALU op" and holds its result.
   localparam logic [OP_W-1:0] ALU_OP_IDLE = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic is_alu_op(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_CPL, OP_AND, OP_OR,
         OP_XOR, OP_RSHIFT, OP_LSHIFT: return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_seq_rf.sv
// 4x8 register file: one synchronous write port, three combinational read ports.
module alu_seq_rf
   import alu_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr1,
   input  logic [ADDR_W-1:0] i_raddr2,
   input  logic [ADDR_W-1:0] i_raddr3,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [DATA_W-1:0] o_rdata2,
   output logic [DATA_W-1:0] o_rdata3
);

   logic [DATA_W-1:0] r_mem [RF_DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RF_DEPTH; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1 = r_mem[i_raddr1];
   assign o_rdata2 = r_mem[i_raddr2];
   assign o_rdata3 = r_mem[i_raddr3];

endmodule

// File: rtl/alu_seq.sv
// Command sequencer driving an external 1-cycle-latency ALU from a 4x8 register file.
// state | meaning: IDLE accept cmd | ISSUE alu_op valid | WAIT result arrives | DONE pulse
module alu_seq
   import alu_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OP_W-1:0]   cmd_op,
   input  logic [ADDR_W-1:0] cmd_src1,
   input  logic [ADDR_W-1:0] cmd_src2,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   input  logic [DATA_W-1:0] alu_result,
   output logic              done,
   output logic [DATA_W-1:0] done_data,
   output logic              err,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_accept;
   logic              w_is_alu;
   logic              w_is_loadi;
   logic              w_rf_we;
   logic [ADDR_W-1:0] w_rf_waddr;
   logic [DATA_W-1:0] w_rf_wdata;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic [ADDR_W-1:0] r_dst;
   logic [OP_W-1:0]   r_alu_op;
   logic [DATA_W-1:0] r_alu_in1;
   logic [DATA_W-1:0] r_alu_in2;
   logic [DATA_W-1:0] r_done_data;
   logic              r_err;

   assign w_accept   = cmd_valid & cmd_ready;
   assign w_is_alu   = is_alu_op(cmd_op);
   assign w_is_loadi = (cmd_op == OP_LOADI);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      done        = 1'b0;
      w_rf_we     = 1'b0;
      w_rf_waddr  = cmd_dst;
      w_rf_wdata  = cmd_imm;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               if (w_is_alu) begin
                  w_state_nxt = ST_ISSUE;
               end else begin
                  w_state_nxt = ST_DONE;
                  w_rf_we     = w_is_loadi;
               end
            end
         end
         ST_ISSUE: w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            w_state_nxt = ST_DONE;
            w_rf_we     = 1'b1;
            w_rf_waddr  = r_dst;
            w_rf_wdata  = alu_result;
         end
         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // alu_op defaults back to idle every cycle so it is only non-zero during ISSUE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_op    <= ALU_OP_IDLE;
         r_alu_in1   <= '0;
         r_alu_in2   <= '0;
         r_dst       <= '0;
         r_done_data <= '0;
         r_err       <= 1'b0;
      end else begin
         r_alu_op <= ALU_OP_IDLE;
         if (w_accept) begin
            if (w_is_alu) begin
               r_alu_op  <= cmd_op;
               r_alu_in1 <= w_rd1;
               r_alu_in2 <= w_rd2;
               r_dst     <= cmd_dst;
            end else if (w_is_loadi) begin
               r_done_data <= cmd_imm;
            end else begin
               r_done_data <= '0;
               r_err       <= 1'b1;
            end
         end
         if (r_state == ST_WAIT) r_done_data <= alu_result;
         if (r_state == ST_DONE) r_err <= 1'b0;
      end
   end

   assign alu_op    = r_alu_op;
   assign alu_in1   = r_alu_in1;
   assign alu_in2   = r_alu_in2;
   assign done_data = r_done_data;
   assign err       = r_err;

   alu_seq_rf u_rf (
      .clk      (clk),
      .rst      (rst),
      .i_we     (w_rf_we),
      .i_waddr  (w_rf_waddr),
      .i_wdata  (w_rf_wdata),
      .i_raddr1 (cmd_src1),
      .i_raddr2 (cmd_src2),
      .i_raddr3 (dbg_addr),
      .o_rdata1 (w_rd1),
      .o_rdata2 (w_rd2),
      .o_rdata3 (dbg_data)
   );

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU attached to the DUT plus a register-file reference model.
module tb_alu_seq;

   localparam logic [7:0] T_LOADI = 8'h00, T_ADD = 8'h01, T_SUB = 8'h02, T_CPL = 8'h0E,
                          T_AND = 8'h0F, T_OR = 8'h10, T_XOR = 8'h11, T_RSH = 8'h13, T_LSH = 8'h14;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_op = 8'h00;
   logic [1:0] cmd_src1 = 2'd0, cmd_src2 = 2'd0, cmd_dst = 2'd0;
   logic [7:0] cmd_imm = 8'h00;
   logic [7:0] alu_op, alu_in1, alu_in2;
   logic [7:0] alu_result;
   logic       done, err;
   logic [7:0] done_data;
   logic [1:0] dbg_addr = 2'd0;
   logic [7:0] dbg_data;

   int checks = 0;
   int errors = 0;
   logic [7:0] m_rf [4];

   always #5 clk = ~clk;

   alu_seq dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst),
      .cmd_imm(cmd_imm), .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_result(alu_result), .done(done), .done_data(done_data), .err(err),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   function automatic logic is_alu(input logic [7:0] op);
      return op inside {T_ADD, T_SUB, T_CPL, T_AND, T_OR, T_XOR, T_RSH, T_LSH};
   endfunction

   function automatic logic [7:0] alu_ref(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         T_ADD:   return a + b;
         T_SUB:   return a - b;
         T_CPL:   return ~a;
         T_AND:   return a & b;
         T_OR:    return a | b;
         T_XOR:   return a ^ b;
         T_RSH:   return a >> 1;
         T_LSH:   return a << 1;
         default: return 8'h00;
      endcase
   endfunction

   // External ALU: one-cycle latency, holds its result for unrecognised opcodes.
   always @(posedge clk or posedge rst) begin
      if (rst)                 alu_result <= 8'h00;
      else if (is_alu(alu_op)) alu_result <= alu_ref(alu_op, alu_in1, alu_in2);
   end

   // Drives one command and reports what came back; lat = 0 means no done pulse seen.
   task automatic run_cmd(input logic [7:0] op, input logic [1:0] s1, input logic [1:0] s2,
                          input logic [1:0] d, input logic [7:0] imm,
                          output logic [7:0] d_data, output logic d_err, output int lat,
                          output logic [7:0] aop1, output logic [7:0] aop_rest);
      int n;
      d_data = 8'hxx; d_err = 1'bx; lat = 0; aop1 = 8'h00; aop_rest = 8'h00;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d; cmd_imm = imm;
      n = 0;
      while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         if (c == 1) aop1 = alu_op;
         else        aop_rest |= alu_op;
         if (done) begin d_data = done_data; d_err = err; lat = c; break; end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      checks++;
      if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || done_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_ctrl got ready %b done %b err %b data %h exp 1 0 0 00", cmd_ready, done, err, done_data);
      end
      checks++;
      if (alu_op !== 8'h00 || alu_in1 !== 8'h00 || alu_in2 !== 8'h00) begin
         errors++;
         $display("FAIL reset_alu got op %h in1 %h in2 %h exp 00 00 00", alu_op, alu_in1, alu_in2);
      end
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i); #1;
         checks++;
         if (dbg_data !== 8'h00) begin errors++; $display("FAIL reset_rf%0d got %h exp 00", i, dbg_data); end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add();
      logic [7:0] dd, a1, ar; logic de; int lat;
      run_cmd(T_LOADI, 2'd0, 2'd0, 2'd0, 8'h05, dd, de, lat, a1, ar);
      checks++;
      if (dd !== 8'h05 || de !== 1'b0 || lat != 1) begin
         errors++; $display("FAIL loadi_r0 got data %h err %b lat %0d exp 05 0 1", dd, de, lat);
      end
      run_cmd(T_LOADI, 2'd0, 2'd0, 2'd1, 8'h03, dd, de, lat, a1, ar);
      run_cmd(T_ADD, 2'd0, 2'd1, 2'd2, 8'h00, dd, de, lat, a1, ar);
      checks++;
      if (dd !== 8'h08 || de !== 1'b0 || lat != 3) begin
         errors++; $display("FAIL add got data %h err %b lat %0d exp 08 0 3", dd, de, lat);
      end
      checks++;
      if (a1 !== T_ADD || ar !== 8'h00) begin
         errors++; $display("FAIL add_aluop got issue %h other %h exp 01 00", a1, ar);
      end
      dbg_addr = 2'd2; #1;
      checks++;
      if (dbg_data !== 8'h08) begin errors++; $display("FAIL add_dbg_r2 got %h exp 08", dbg_data); end
   endtask

   task automatic test_sub();
      logic [7:0] dd, a1, ar; logic de; int lat;
      run_cmd(T_SUB, 2'd0, 2'd1, 2'd3, 8'h00, dd, de, lat, a1, ar);
      checks++;
      if (dd !== 8'h02 || lat != 3) begin errors++; $display("FAIL sub got data %h lat %0d exp 02 3", dd, lat); end
      run_cmd(T_SUB, 2'd1, 2'd0, 2'd3, 8'h00, dd, de, lat, a1, ar);
      checks++;
      if (dd !== 8'hFE || lat != 3) begin errors++; $display("FAIL sub_wrap got data %h lat %0d exp FE 3", dd, lat); end
      dbg_addr = 2'd3; #1;
      checks++;
      if (dbg_data !== 8'hFE) begin errors++; $display("FAIL sub_dbg_r3 got %h exp FE", dbg_data); end
   endtask

   task automatic test_shift_xor();
      logic [7:0] dd, a1, ar; logic de; int lat;
      run_cmd(T_LOADI, 2'd0, 2'd0, 2'd0, 8'h81, dd, de, lat, a1, ar);
      run_cmd(T_RSH, 2'd0, 2'd0, 2'd0, 8'h00, dd, de, lat, a1, ar);
      dbg_addr = 2'd0; #1;
      checks++;
      if (dd !== 8'h40 || dbg_data !== 8'h40) begin
         errors++; $display("FAIL rshift got data %h r0 %h exp 40 40", dd, dbg_data);
      end
      run_cmd(T_LOADI, 2'd0, 2'd0, 2'd0, 8'h81, dd, de, lat, a1, ar);
      run_cmd(T_LSH, 2'd0, 2'd0, 2'd1, 8'h00, dd, de, lat, a1, ar);
      checks++;
      if (dd !== 8'h02) begin errors++; $display("FAIL lshift got %h exp 02", dd); end
      run_cmd(T_LOADI, 2'd0, 2'd0, 2'd0, 8'h0F, dd, de, lat, a1, ar);
      run_cmd(T_LOADI, 2'd0, 2'd0, 2'd1, 8'hFF, dd, de, lat, a1, ar);
      run_cmd(T_XOR, 2'd0, 2'd1, 2'd2, 8'h00, dd, de, lat, a1, ar);
      checks++;
      if (dd !== 8'hF0) begin errors++; $display("FAIL xor got %h exp F0", dd); end
   endtask

   task automatic test_illegal();
      logic [7:0] dd, a1, ar; logic de; int lat;
      logic [7:0] vals [4];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 4; i++) run_cmd(T_LOADI, 2'd0, 2'd0, 2'(i), vals[i], dd, de, lat, a1, ar);
      run_cmd(8'h07, 2'd1, 2'd2, 2'd3, 8'h99, dd, de, lat, a1, ar);
      checks++;
      if (dd !== 8'h00 || de !== 1'b1 || lat != 1) begin
         errors++; $display("FAIL illegal got data %h err %b lat %0d exp 00 1 1", dd, de, lat);
      end
      checks++;
      if (a1 !== 8'h00 || ar !== 8'h00) begin
         errors++; $display("FAIL illegal_aluop got %h %h exp 00 00", a1, ar);
      end
      for (int i = 0; i < 4; i++) begin
         dbg_addr = 2'(i); #1;
         checks++;
         if (dbg_data !== vals[i]) begin errors++; $display("FAIL illegal_rf%0d got %h exp %h", i, dbg_data, vals[i]); end
      end
      run_cmd(T_LOADI, 2'd0, 2'd0, 2'd0, 8'h5A, dd, de, lat, a1, ar);
      checks++;
      if (de !== 1'b0 || dd !== 8'h5A) begin
         errors++; $display("FAIL err_cleared got err %b data %h exp 0 5A", de, dd);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] dd, a1, ar; logic de; int lat;
      int n_rdy, n_done;
      int rdy_c [8];
      int done_c [8];
      run_cmd(T_LOADI, 2'd0, 2'd0, 2'd0, 8'h00, dd, de, lat, a1, ar);
      run_cmd(T_LOADI, 2'd0, 2'd0, 2'd1, 8'h07, dd, de, lat, a1, ar);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = T_ADD; cmd_src1 = 2'd0; cmd_src2 = 2'd1; cmd_dst = 2'd0;
      n_rdy = 0; n_done = 0;
      for (int c = 0; c < 40; c++) begin
         if (cmd_ready) begin if (n_rdy < 8) rdy_c[n_rdy] = c; n_rdy++; end
         if (done) begin if (n_done < 8) done_c[n_done] = c; n_done++; end
         if (n_done == 4) break;
         @(negedge clk);
         if (n_rdy >= 4) cmd_valid = 1'b0;
      end
      cmd_valid = 1'b0;
      checks++;
      if (n_done != 4 || n_rdy != 4) begin
         errors++; $display("FAIL b2b_counts got done %0d ready %0d exp 4 4", n_done, n_rdy);
      end
      for (int k = 0; k < 4 && k < n_done && k < n_rdy; k++) begin
         checks++;
         if (rdy_c[k] != 4 * k || done_c[k] != 4 * k + 3) begin
            errors++;
            $display("FAIL b2b_timing%0d got ready@%0d done@%0d exp %0d %0d", k, rdy_c[k], done_c[k], 4 * k, 4 * k + 3);
         end
      end
      dbg_addr = 2'd0; #1;
      checks++;
      if (dbg_data !== 8'h1C) begin errors++; $display("FAIL b2b_once got r0 %h exp 1C", dbg_data); end
   endtask

   task automatic test_reset_mid();
      logic seen_done;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = T_ADD; cmd_src1 = 2'd0; cmd_src2 = 2'd1; cmd_dst = 2'd2;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1; #1;
      checks++;
      if (done !== 1'b0 || alu_op !== 8'h00 || done_data !== 8'h00) begin
         errors++; $display("FAIL rstmid_async got done %b op %h data %h exp 0 00 00", done, alu_op, done_data);
      end
      @(negedge clk);
      rst = 1'b0; #1;
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", cmd_ready); end
      seen_done = 1'b0;
      for (int c = 0; c < 6; c++) begin @(negedge clk); if (done) seen_done = 1'b1; end
      checks++;
      if (seen_done !== 1'b0) begin errors++; $display("FAIL rstmid_nodone got pulse exp none"); end
      for (int i = 0; i < 4; i++) begin
         m_rf[i] = 8'h00;
         dbg_addr = 2'(i); #1;
         checks++;
         if (dbg_data !== 8'h00) begin errors++; $display("FAIL rstmid_rf%0d got %h exp 00", i, dbg_data); end
      end
   endtask

   task automatic test_random();
      logic [7:0] ops [12];
      logic [7:0] op, imm, exp_d, dd, a1, ar;
      logic [1:0] s1, s2, d;
      logic exp_e, de;
      int exp_l, lat;
      ops = '{T_LOADI, T_ADD, T_SUB, T_CPL, T_AND, T_OR, T_XOR, T_RSH, T_LSH, 8'h07, 8'h03, 8'hA5};
      for (int k = 0; k < 40; k++) begin
         op  = ops[$urandom_range(0, 11)];
         s1  = 2'($urandom_range(0, 3));
         s2  = 2'($urandom_range(0, 3));
         d   = 2'($urandom_range(0, 3));
         imm = 8'($urandom);
         if (op == T_LOADI) begin exp_d = imm; exp_e = 1'b0; exp_l = 1; end
         else if (is_alu(op)) begin exp_d = alu_ref(op, m_rf[s1], m_rf[s2]); exp_e = 1'b0; exp_l = 3; end
         else begin exp_d = 8'h00; exp_e = 1'b1; exp_l = 1; end
         run_cmd(op, s1, s2, d, imm, dd, de, lat, a1, ar);
         if (!exp_e) m_rf[d] = exp_d;
         checks++;
         if (dd !== exp_d || de !== exp_e || lat != exp_l) begin
            errors++;
            $display("FAIL rand%0d op %h got data %h err %b lat %0d exp %h %b %0d", k, op, dd, de, lat, exp_d, exp_e, exp_l);
         end
         for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i); #1;
            checks++;
            if (dbg_data !== m_rf[i]) begin
               errors++; $display("FAIL rand%0d_rf%0d got %h exp %h", k, i, dbg_data, m_rf[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_shift_xor();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "timeout");
   end

endmodule
